// File: rtl/mac_acc_pkg.sv
// Shared types and saturation helpers for the MAC partial-sum accumulator.
package mac_acc_pkg;

  localparam int MUL_RES_W = 18;
  // Storage width of a FIFO result entry; the top's OUT_W must not exceed it.
  localparam int PKG_OUT_W = 24;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } pipe_tag_t;

  typedef struct packed {
    logic [PKG_OUT_W-1:0] dat;
    logic                 sat;
  } out_entry_t;

  // Clamp a value to the signed range of a w-bit number; clip reports clamping.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int w,
                                                output logic clip);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      clip   = 1'b1;
      sat_to = hi;
    end else if (v < lo) begin
      clip   = 1'b1;
      sat_to = lo;
    end else begin
      clip   = 1'b0;
      sat_to = v;
    end
  endfunction

  // Saturating add at w-bit signed limits (operands already sign-extended).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w,
                                                 output logic clip);
    sat_add = sat_to(a + b, w, clip);
  endfunction

  // Clip an accumulator value to the w-bit signed output range.
  function automatic logic signed [63:0] clip_to(input logic signed [63:0] v,
                                                 input int w,
                                                 output logic clip);
    clip_to = sat_to(v, w, clip);
  endfunction

endpackage

// File: rtl/mac_acc_fifo.sv
// Small synchronous FIFO of finished dot-product results with occupancy count.
module mac_acc_fifo
  import mac_acc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  out_entry_t       push_ent,
  input  logic             pop,
  output out_entry_t       head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  out_entry_t       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign pop_ok_s  = pop && (count_r != '0);
  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign push_ok_s = push && ((count_r < CNT_W'(DEPTH)) || pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Next occupancy from the qualified push/pop pair
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_ent;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/mac_psum_acc.sv
// Dot-product accumulator behind the fixed-latency multiplier, with credit flow control.
module mac_psum_acc
  import mac_acc_pkg::*;
#(
  parameter int MUL_LAT   = 4,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 24,
  parameter int OUT_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_vld,
  input  logic                        in_last,
  output logic                        in_rdy,
  input  logic signed [MUL_RES_W-1:0] mul_res,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic signed [OUT_W-1:0]     out_dat,
  output logic                        out_sat
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  pipe_tag_t               tag_r [MUL_LAT];
  pipe_tag_t               tag_in_s;
  pipe_tag_t               tag_d_s;
  logic                    acc_issue_s;
  logic                    first_s;
  logic                    in_vec_r;
  logic                    in_vec_nxt_s;
  logic                    in_rdy_r;
  logic [CNT_W-1:0]        reserved_r;
  logic [CNT_W-1:0]        reserved_nxt_s;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] acc_nxt_s;
  logic signed [ACC_W-1:0] acc_sum_s;
  logic                    ovf_r;
  logic                    ovf_nxt_s;
  logic                    add_clip_s;
  logic                    out_clip_s;
  logic                    push_s;
  logic                    pop_s;
  out_entry_t              push_ent_s;
  out_entry_t              head_s;
  logic [CNT_W-1:0]        fifo_cnt_s;

  assign acc_issue_s = in_vld && in_rdy_r;
  assign first_s     = acc_issue_s && !in_vec_r;
  assign tag_d_s     = tag_r[MUL_LAT-1];
  assign pop_s       = out_vld && out_rdy;
  assign in_rdy      = in_rdy_r;
  assign out_vld     = (fifo_cnt_s != '0);
  assign out_dat     = head_s.dat[OUT_W-1:0];
  assign out_sat     = head_s.sat;

  // Tag entering the delay line this cycle
  always_comb begin
    tag_in_s       = '0;
    tag_in_s.vld   = acc_issue_s;
    tag_in_s.first = first_s;
    tag_in_s.last  = acc_issue_s && in_last;
  end

  // Tag delay line, aligned so the last stage matches mul_res
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      tag_r[0] <= tag_in_s;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Accumulate, sticky overflow and result formation for the push
  always_comb begin
    acc_nxt_s  = acc_r;
    ovf_nxt_s  = ovf_r;
    add_clip_s = 1'b0;
    out_clip_s = 1'b0;
    push_ent_s = '0;
    acc_sum_s  = ACC_W'(sat_add(64'(acc_r), 64'(mul_res), ACC_W, add_clip_s));
    if (tag_d_s.vld) begin
      if (tag_d_s.first) begin
        acc_nxt_s = ACC_W'(mul_res);
        ovf_nxt_s = 1'b0;
      end else begin
        acc_nxt_s = acc_sum_s;
        ovf_nxt_s = ovf_r || add_clip_s;
      end
    end else begin
      acc_nxt_s = acc_r;
      ovf_nxt_s = ovf_r;
    end
    push_s         = tag_d_s.vld && tag_d_s.last;
    push_ent_s.dat = PKG_OUT_W'(clip_to(64'(acc_nxt_s), OUT_W, out_clip_s));
    push_ent_s.sat = ovf_nxt_s || out_clip_s;
  end

  // Accumulator and sticky overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else begin
      acc_r <= acc_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  // Vector framing and credit bookkeeping for the next cycle
  always_comb begin
    in_vec_nxt_s   = in_vec_r;
    reserved_nxt_s = reserved_r;
    if (acc_issue_s) begin
      in_vec_nxt_s = !in_last;
    end else begin
      in_vec_nxt_s = in_vec_r;
    end
    if (first_s && !pop_s) begin
      reserved_nxt_s = reserved_r + CNT_W'(1);
    end else if (!first_s && pop_s) begin
      reserved_nxt_s = reserved_r - CNT_W'(1);
    end else begin
      reserved_nxt_s = reserved_r;
    end
  end

  // Framing, credit count and registered in_rdy (mid-vector terms never blocked)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vec_r   <= 1'b0;
      reserved_r <= '0;
      in_rdy_r   <= 1'b1;
    end else begin
      in_vec_r   <= in_vec_nxt_s;
      reserved_r <= reserved_nxt_s;
      in_rdy_r   <= in_vec_nxt_s || (reserved_nxt_s < CNT_W'(OUT_DEPTH));
    end
  end

  mac_acc_fifo #(
    .DEPTH (OUT_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .push_ent (push_ent_s),
    .pop      (pop_s),
    .head     (head_s),
    .count    (fifo_cnt_s)
  );

endmodule

// File: tb/tb_mac_psum_acc.sv
// Directed, table-driven bench for mac_psum_acc with a scheduled mul_res stream.
module tb_mac_psum_acc;
  import mac_acc_pkg::*;

  localparam int LAT = 4;

  typedef struct {
    int len;
    int a;
    int b;
    int c;
    int exp_dat;
    bit exp_sat;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               in_vld;
  logic               in_last;
  logic               in_rdy;
  logic signed [17:0] mul_res;
  logic               out_vld;
  logic               out_rdy;
  logic signed [23:0] out_dat;
  logic               out_sat;

  int                 checks;
  int                 passes;
  int                 cyc;
  logic signed [17:0] sched [0:4095];
  out_entry_t         got_q [$];
  vec_t               tbl [6];

  mac_psum_acc #(
    .MUL_LAT   (4),
    .ACC_W     (32),
    .OUT_W     (24),
    .OUT_DEPTH (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_last (in_last),
    .in_rdy  (in_rdy),
    .mul_res (mul_res),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_dat (out_dat),
    .out_sat (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock; record any pop happening at this edge.
  task automatic step();
    if (out_vld && out_rdy) got_q.push_back('{dat: out_dat, sat: out_sat});
    @(posedge clk);
    #1;
    cyc++;
    mul_res = sched[cyc];
  endtask

  // Issue one term (waiting for in_rdy), schedule its product LAT cycles later.
  task automatic issue(input int v, input bit last, output int at);
    int w;
    w = 0;
    in_vld = 1'b0;
    while (!in_rdy && w < 60) begin
      step();
      w++;
    end
    if (!in_rdy) check("issue rdy timeout", 0, 1);
    in_vld  = 1'b1;
    in_last = last;
    sched[cyc + LAT] = 18'(v);
    at = cyc;
    step();
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic expect_out(input string nm, input longint d, input bit s);
    out_entry_t e;
    check({nm, " present"}, longint'(got_q.size() > 0), 1);
    if (got_q.size() > 0) begin
      e = got_q.pop_front();
      check({nm, " dat"}, longint'($signed(e.dat)), d);
      check({nm, " sat"}, longint'(e.sat), longint'(s));
    end
  endtask

  initial begin
    int at;
    int w;
    int v;
    checks = 0;
    passes = 0;
    cyc    = 0;
    for (int i = 0; i < 4096; i++) sched[i] = 18'(i * 37 + 1001);
    tbl[0] = '{3, 100, -50, 7, 57, 1'b0};
    tbl[1] = '{1, -131072, 0, 0, -131072, 1'b0};
    tbl[2] = '{128, 131071, 131071, 131071, 8388607, 1'b1};
    tbl[3] = '{1, 5, 0, 0, 5, 1'b0};
    tbl[4] = '{70, -131072, -131072, -131072, -8388608, 1'b1};
    tbl[5] = '{2, 3, 4, 0, 7, 1'b0};

    rst_n   = 1'b1;
    in_vld  = 1'b0;
    in_last = 1'b0;
    out_rdy = 1'b0;
    mul_res = sched[0];
    #2 rst_n = 1'b0;
    #1;
    check("reset in_rdy", in_rdy, 1);
    check("reset out_vld", out_vld, 0);
    check("reset out_dat", out_dat, 0);
    check("reset out_sat", out_sat, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Table-driven vectors with out_rdy held high
    out_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      got_q.delete();
      for (int i = 0; i < tbl[k].len; i++) begin
        v = (i == 0) ? tbl[k].a : ((i == 1) ? tbl[k].b : tbl[k].c);
        issue(v, (i == tbl[k].len - 1), at);
      end
      w = 0;
      while (!out_vld && w < 20) begin
        step();
        w++;
      end
      check($sformatf("vec%0d latency", k), cyc - at, LAT + 1);
      step();
      expect_out($sformatf("vec%0d", k), tbl[k].exp_dat, tbl[k].exp_sat);
    end

    // Back-to-back single-term vectors: two credits, then stall until a pop
    got_q.delete();
    check("b2b rdy first", in_rdy, 1);
    in_vld = 1'b1; in_last = 1'b1; sched[cyc + LAT] = 18'sd11;
    step();
    check("b2b rdy second", in_rdy, 1);
    sched[cyc + LAT] = 18'sd12;
    step();
    in_vld = 1'b0; in_last = 1'b0;
    check("b2b rdy third blocked", in_rdy, 0);
    for (int i = 13; i <= 16; i++) issue(i, 1'b1, at);
    for (int i = 0; i < 15; i++) step();
    for (int i = 11; i <= 16; i++) expect_out($sformatf("b2b %0d", i), i, 1'b0);
    check("b2b no extra", got_q.size(), 0);

    // Backpressure: third 2-term vector held off until one pop
    got_q.delete();
    out_rdy = 1'b0;
    issue(10, 1'b0, at);
    issue(20, 1'b1, at);
    issue(-5, 1'b0, at);
    issue(-6, 1'b1, at);
    check("bp third blocked", in_rdy, 0);
    for (int i = 0; i < 15; i++) step();
    check("bp still blocked", in_rdy, 0);
    check("bp head valid", out_vld, 1);
    check("bp head dat", out_dat, 30);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    check("bp rdy after pop", in_rdy, 1);
    issue(1000, 1'b0, at);
    issue(1, 1'b1, at);
    for (int i = 0; i < 10; i++) step();
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) step();
    expect_out("bp A", 30, 1'b0);
    expect_out("bp B", -11, 1'b0);
    expect_out("bp C", 1001, 1'b0);
    check("bp no dup", got_q.size(), 0);

    // Reset mid-vector with one FIFO entry held
    got_q.delete();
    out_rdy = 1'b0;
    issue(9, 1'b1, at);
    for (int i = 0; i < 8; i++) step();
    check("rst pre held", out_vld, 1);
    issue(50, 1'b0, at);
    issue(60, 1'b0, at);
    #2 rst_n = 1'b0;
    #1;
    check("rst out_vld", out_vld, 0);
    check("rst in_rdy", in_rdy, 1);
    check("rst out_dat", out_dat, 0);
    step();
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    in_last = 1'b1;
    for (int i = 0; i < 12; i++) step();
    in_last = 1'b0;
    check("rst no stale out", got_q.size(), 0);
    check("rst idle out_vld", out_vld, 0);
    issue(1, 1'b0, at);
    issue(2, 1'b1, at);
    for (int i = 0; i < 10; i++) step();
    expect_out("rst new vec", 3, 1'b0);
    check("rst no extra", got_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
